// File: rtl/led_fx_pkg.sv
// Shared definitions for the led8 effect blocks: frame constants, the
// drain FSM state type and small frame helpers.
package led_fx_pkg;

    localparam int         LED_N       = 8;
    localparam logic [7:0] FRAME_FULL  = 8'hFF;
    localparam logic [7:0] FRAME_EMPTY = 8'h00;

    typedef enum logic [1:0] {
        STACK,
        MOVE,
        EMPTY
    } drain_state_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] f);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = f[7-i];
        return r;
    endfunction

    // Bits 7 down to 8-h set; h=0 gives an empty mask, h=8 a full one.
    function automatic logic [7:0] stack_mask(input logic [3:0] h);
        return ~(8'hFF >> h);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Animation step prescaler: one-cycle step every TICK_DIV enabled cycles.
// Freezes (count held, no step) while en is low.
module led_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic step
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign step = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_unstack_drain.sv
// Unstack-and-drain LED effect: a full bar sheds one LED per detach step,
// each shed LED walks to the open end and falls off; the empty bar refills.
module led_unstack_drain
    import led_fx_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int LED_N    = led_fx_pkg::LED_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    output logic [LED_N-1:0] q,
    output logic             wrap
);

    logic step;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .step  (step)
    );

    drain_state_t     state, state_nx;
    logic [3:0]       h, h_nx;
    logic             mv, mv_nx;
    logic [2:0]       pos, pos_nx;
    logic             ldir, ldir_nx;
    logic             wrap_nx;
    logic [3:0]       b;
    logic [7:0]       frame_nx;
    logic [LED_N-1:0] q_nx;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        h_nx     = h;
        mv_nx    = mv;
        pos_nx   = pos;
        ldir_nx  = ldir;
        wrap_nx  = 1'b0;
        b        = 4'(LED_N) - h;

        if (step) begin
            case (state)
                STACK: begin
                    h_nx = h - 4'd1;
                    if (b == 4'd0) begin
                        state_nx = (h_nx != 4'd0) ? STACK : EMPTY;
                    end else begin
                        mv_nx    = 1'b1;
                        pos_nx   = 3'(b - 4'd1);
                        state_nx = MOVE;
                    end
                end
                MOVE: begin
                    if (pos != 3'd0) begin
                        pos_nx = pos - 3'd1;
                    end else begin
                        mv_nx    = 1'b0;
                        state_nx = (h != 4'd0) ? STACK : EMPTY;
                    end
                end
                EMPTY: begin
                    h_nx     = 4'(LED_N);
                    ldir_nx  = dir;
                    wrap_nx  = 1'b1;
                    state_nx = STACK;
                end
                default: state_nx = STACK;
            endcase
        end

        // The frame is built from next-state values so q changes on the step edge itself.
        frame_nx = stack_mask(h_nx) | (mv_nx ? (8'h01 << pos_nx) : FRAME_EMPTY);
        q_nx     = ldir_nx ? bit_rev8(frame_nx) : frame_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STACK;
            h     <= 4'(LED_N);
            mv    <= 1'b0;
            pos   <= 3'd0;
            ldir  <= 1'b0;
            q     <= FRAME_FULL;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            h     <= h_nx;
            mv    <= mv_nx;
            pos   <= pos_nx;
            ldir  <= ldir_nx;
            q     <= q_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_led_unstack_drain.sv
// Self-checking bench for led_unstack_drain: two instances (TICK_DIV=4 and 1)
// compared every cycle against a phase-indexed frame table model.
module tb_led_unstack_drain;

    localparam int PERIOD = 37;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       dir;
    logic [7:0] q4, q1;
    logic       wrap4, wrap1;

    led_unstack_drain #(.TICK_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .dir   (dir),
        .q     (q4),
        .wrap  (wrap4)
    );

    led_unstack_drain #(.TICK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .dir   (dir),
        .q     (q1),
        .wrap  (wrap1)
    );

    always #5 clk = ~clk;

    // Reference model: one period as a table of dir=0 frames, indexed by phase.
    logic [7:0] seq [PERIOD];
    int         tdiv [2] = '{4, 1};
    int         m_ph [2] = '{0, 0};
    int         m_cnt[2] = '{0, 0};
    logic       m_dir [2] = '{1'b0, 1'b0};
    logic       m_wrap[2] = '{1'b0, 1'b0};

    function automatic void build_seq();
        int         n;
        logic [7:0] stk;
        n = 0;
        seq[n] = 8'hFF; n++;
        for (int b = 0; b < 8; b++) begin
            stk = 8'hFF << (b + 1);
            for (int p = b - 1; p >= 0; p--) begin
                seq[n] = stk | (8'h01 << p); n++;
            end
            seq[n] = stk; n++;
        end
    endfunction

    function automatic logic [7:0] rev(input logic [7:0] f);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = f[7-i];
        return r;
    endfunction

    function automatic logic [7:0] exp_q(input int i);
        return m_dir[i] ? rev(seq[m_ph[i]]) : seq[m_ph[i]];
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ph[i] = 0; m_cnt[i] = 0; m_dir[i] = 1'b0; m_wrap[i] = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (en) begin
                    if (m_cnt[i] == tdiv[i] - 1) begin
                        m_cnt[i] = 0;
                        m_ph[i]  = (m_ph[i] + 1) % PERIOD;
                        if (m_ph[i] == 0) begin
                            m_wrap[i] = 1'b1;
                            m_dir[i]  = dir;
                        end
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/q4"},    q4,              exp_q(0));
        check({tag, "/wrap4"}, {7'b0, wrap4},   {7'b0, m_wrap[0]});
        check({tag, "/q1"},    q1,              exp_q(1));
        check({tag, "/wrap1"}, {7'b0, wrap1},   {7'b0, m_wrap[1]});
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_model(tag);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_model("rst");
        reset = 1'b0;
    endtask

    logic [7:0] exp4 [7] = '{8'hFE, 8'hFD, 8'hFC, 8'hFA, 8'hF9, 8'hF8, 8'hF4};
    logic [7:0] mir  [7] = '{8'hFF, 8'h7F, 8'hBF, 8'h3F, 8'h5F, 8'h9F, 8'h1F};

    initial begin
        build_seq();
        reset = 1'b1; en = 1'b0; dir = 1'b0;
        @(negedge clk);
        check_model("reset");
        check("reset_q4", q4, 8'hFF);
        check("reset_wrap4", {7'b0, wrap4}, 8'h00);
        reset = 1'b0; en = 1'b1;

        // Async reset mid-MOVE at frame FA, no clock edge involved.
        cyc(16, "pre_fa");
        check("mid_move_fa", q4, 8'hFA);
        #2 reset = 1'b1;
        #1;
        check("async_q4",    q4,            8'hFF);
        check("async_wrap4", {7'b0, wrap4}, 8'h00);
        check("async_q1",    q1,            8'hFF);
        @(negedge clk);
        reset = 1'b0;
        cyc(3, "first_wait");
        check("first_hold", q4, 8'hFF);
        cyc(1, "first_step");
        check("first_step_q4", q4, exp4[0]);

        // TICK_DIV=4 frame sequence, constant between steps.
        for (int k = 1; k < 7; k++) begin
            cyc(3, "hold4");
            check("hold4_q", q4, exp4[k-1]);
            cyc(1, "step4");
            check("step4_q", q4, exp4[k]);
        end

        // Full period on TICK_DIV=1 with a mid-sequence dir change.
        do_reset();
        en = 1'b1; dir = 1'b0;
        cyc(10, "dir0_run");
        dir = 1'b1;
        cyc(26, "dir_ignored");
        check("step36_q1", q1, 8'h00);
        cyc(1, "refill");
        check("step37_q1",    q1,            8'hFF);
        check("step37_wrap1", {7'b0, wrap1}, 8'h01);
        for (int k = 1; k < 7; k++) begin
            cyc(1, "mirrored");
            check("mirrored_q1",   q1,            mir[k]);
            check("mirrored_wrap", {7'b0, wrap1}, 8'h00);
        end
        dir = 1'b0;
        cyc(30, "second_period");
        check("step73_q1", q1, 8'h00);
        cyc(1, "refill2");
        check("step74_wrap1", {7'b0, wrap1}, 8'h01);
        cyc(1, "repeat1");
        check("repeat_fe", q1, 8'hFE);
        cyc(1, "repeat2");
        check("repeat_fd", q1, 8'hFD);

        // en low in MOVE with prescaler count 2 (TICK_DIV=4).
        do_reset();
        en = 1'b1;
        cyc(10, "to_move");
        check("move_fd", q4, 8'hFD);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, "frozen");
            check("frozen_q4", q4, 8'hFD);
        end
        en = 1'b1;
        cyc(1, "resume1");
        check("resume1_q4", q4, 8'hFD);
        cyc(1, "resume2");
        check("resume2_q4", q4, 8'hFC);

        // en low across EMPTY (TICK_DIV=1).
        do_reset();
        en = 1'b1;
        cyc(36, "to_empty");
        check("empty_q1", q1, 8'h00);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, "empty_frozen");
            check("empty_wrap1", {7'b0, wrap1}, 8'h00);
            check("empty_q1",    q1,            8'h00);
        end
        en = 1'b1;
        cyc(1, "empty_resume");
        check("empty_resume_q1",   q1,            8'hFF);
        check("empty_resume_wrap", {7'b0, wrap1}, 8'h01);
        cyc(1, "wrap_drop");
        check("wrap_drop", {7'b0, wrap1}, 8'h00);

        // Random en/dir against the model.
        repeat (400) begin
            en  = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom_range(0, 1));
            cyc(1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
